// File: rtl/viterbi_sequencer.sv
// ---------------------------------------------------------------------------
// viterbi_sequencer
//
// Control sequencer for viterbi_core. It holds the active channel estimate and
// produces the core's update / initialize / run strobes. It admits RSE samples
// only while the core is running and tracks which final_symbols outputs carry
// real decisions rather than history-fill decisions. A channel reload can only
// land in IDLE or RUN. It is then followed by a fresh UPDATE and INIT, so the
// core never decodes with a half-applied estimate.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   enable       permission to leave IDLE and to stay in RUN
//   chan_valid   a new channel estimate is offered on chan_in
//   chan_ready   estimate can be accepted (IDLE or RUN)
//   chan_in      offered estimate, est_chan_depth signed taps
//   est_channel  active estimate driven to the core
//   update       core precompute strobe (UPDATE_CYCLES cycles)
//   initialize   core path-metric initialize strobe (one cycle)
//   run          core advance strobe (RUN and in_valid)
//   in_valid     RSE sample present at the core input
//   in_ready     samples are consumed this cycle (RUN)
//   out_valid    core final_symbols are valid this cycle
//   state        FSM state: IDLE=0, UPDATE=1, INIT=2, RUN=3
// ---------------------------------------------------------------------------
module viterbi_sequencer #(
  parameter int est_channel_width = 8,
  parameter int est_chan_depth    = 30,
  parameter int UPDATE_CYCLES     = 3,
  parameter int FILL_SAMPLES      = 8,
  parameter int DECODE_LAT        = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                chan_valid,
  output logic                                chan_ready,
  input  logic signed [est_channel_width-1:0] chan_in     [est_chan_depth],
  output logic signed [est_channel_width-1:0] est_channel [est_chan_depth],
  output logic                                update,
  output logic                                initialize,
  output logic                                run,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                out_valid,
  output logic [1:0]                          state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_INIT   = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int UW = $clog2(UPDATE_CYCLES + 1);
  localparam int SW = $clog2(FILL_SAMPLES + 1);
  localparam logic [UW-1:0] UPD_LAST = UW'(UPDATE_CYCLES - 1);
  localparam logic [SW-1:0] FILL_MAX = SW'(FILL_SAMPLES);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    loaded_r;
  logic [UW-1:0]           upd_cnt_r;
  logic [SW-1:0]           samp_cnt_r;
  logic [DECODE_LAT-1:0]   vpipe_r;
  logic                    chan_acc_s;
  logic                    samp_acc_s;
  logic                    leave_run_s;
  logic                    fill_done_s;

  // Moore decode of the handshake readies and core strobes from the state register
  always_comb begin
    chan_ready = 1'b0;
    update     = 1'b0;
    initialize = 1'b0;
    in_ready   = 1'b0;
    run        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        chan_ready = 1'b1;
      end
      ST_UPDATE: begin
        update = 1'b1;
      end
      ST_INIT: begin
        initialize = 1'b1;
      end
      ST_RUN: begin
        chan_ready = 1'b1;
        in_ready   = 1'b1;
        run        = in_valid;
      end
      default: begin
        chan_ready = 1'b0;
      end
    endcase
  end

  // Handshake events and fill status used by the FSM and the pipeline tracker
  always_comb begin
    chan_acc_s  = chan_valid & chan_ready;
    samp_acc_s  = in_valid & in_ready;
    // samp_cnt_r saturates at FILL_MAX, so equality means the history is full
    fill_done_s = (samp_cnt_r == FILL_MAX);
    leave_run_s = (state_r == ST_RUN) && (state_nxt_s != ST_RUN);
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        // A fresh estimate or one parked earlier starts the core once enabled
        if (enable && (chan_acc_s || loaded_r)) begin
          state_nxt_s = ST_UPDATE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (upd_cnt_r == UPD_LAST) begin
          state_nxt_s = ST_INIT;
        end else begin
          state_nxt_s = ST_UPDATE;
        end
      end
      ST_INIT: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        // A reload wins over disable so the new estimate is always precomputed
        if (chan_acc_s) begin
          state_nxt_s = ST_UPDATE;
        end else if (!enable) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and the sticky "estimate loaded" flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      loaded_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (chan_acc_s) begin
        loaded_r <= 1'b1;
      end
    end
  end

  // Active channel estimate, replaced only on an accepted handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < est_chan_depth; i++) begin
        est_channel[i] <= {est_channel_width{1'b0}};
      end
    end else if (chan_acc_s) begin
      est_channel <= chan_in;
    end
  end

  // UPDATE dwell counter, zero whenever the FSM is outside UPDATE
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_cnt_r <= {UW{1'b0}};
    end else if ((state_r == ST_UPDATE) && (state_nxt_s == ST_UPDATE)) begin
      upd_cnt_r <= upd_cnt_r + {{(UW-1){1'b0}}, 1'b1};
    end else begin
      upd_cnt_r <= {UW{1'b0}};
    end
  end

  // Samples accepted since INIT, saturating once the history is filled
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt_r <= {SW{1'b0}};
    end else if (state_r == ST_INIT) begin
      samp_cnt_r <= {SW{1'b0}};
    end else if (samp_acc_s && !fill_done_s) begin
      samp_cnt_r <= samp_cnt_r + {{(SW-1){1'b0}}, 1'b1};
    end
  end

  // Valid-decision tracker mirroring the core decode latency; flushed on RUN exit
  always_ff @(posedge clk) begin
    if (rst || leave_run_s) begin
      vpipe_r <= {DECODE_LAT{1'b0}};
    end else begin
      for (int i = DECODE_LAT - 1; i > 0; i--) begin
        vpipe_r[i] <= vpipe_r[i-1];
      end
      vpipe_r[0] <= samp_acc_s & fill_done_s;
    end
  end

  assign out_valid = vpipe_r[DECODE_LAT-1];
  assign state     = state_r;

endmodule

// File: doc/viterbi_sequencer.md
# viterbi_sequencer

Control sequencer for `viterbi_core`. It owns the active channel-estimate register and generates the core's `update`, `initialize` and `run` strobes. It gates the received-sample stream into the core and marks which `final_symbols` outputs are valid. It sits between the channel-estimation/RSE front end and `viterbi_core`, so channel reloads are never applied while the core is decoding.

## Interface
Parameters:
- `est_channel_width`, 8, bit width of each channel tap.
- `est_chan_depth`, 30, number of channel taps.
- `UPDATE_CYCLES`, 3, cycles `update` is held so the state and branch register units settle.
- `FILL_SAMPLES`, 8, accepted samples after `initialize` whose decisions are discarded (history fill).
- `DECODE_LAT`, 4, cycles from sample acceptance to the corresponding `final_symbols` being valid at the core output.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permission to leave IDLE and remain in RUN.
- `chan_valid`  in  1  a new channel estimate is offered.
- `chan_ready`  out  1  the sequencer can accept a channel estimate.
- `chan_in`  in  signed [est_channel_width-1:0] x [est_chan_depth]  offered estimate.
- `est_channel`  out  signed [est_channel_width-1:0] x [est_chan_depth]  active estimate to the core.
- `update`  out  1  core precompute strobe.
- `initialize`  out  1  core path-metric initialize strobe.
- `run`  out  1  core advance strobe.
- `in_valid`  in  1  an RSE sample vector is present at the core input.
- `in_ready`  out  1  the sequencer consumes samples this cycle.
- `out_valid`  out  1  core `final_symbols` are valid this cycle.
- `state`  out  2  FSM state: IDLE=0, UPDATE=1, INIT=2, RUN=3.

## Operation
- Channel handshake: an estimate is accepted when `chan_valid & chan_ready`. `chan_ready = (state==IDLE) | (state==RUN)`. On acceptance, `est_channel <= chan_in` and the `loaded` flag is set. `est_channel` changes only on acceptance.
- IDLE: all strobes are 0.
  - Acceptance with `enable=1` goes to UPDATE.
  - Acceptance with `enable=0` stays in IDLE with `loaded=1`.
  - `enable & loaded` goes to UPDATE.
- UPDATE: `update=1`. `upd_cnt` counts 0..UPDATE_CYCLES-1. At the last count the FSM goes to INIT, so the state lasts exactly UPDATE_CYCLES cycles. `enable` is ignored.
- INIT: `initialize=1` for exactly one cycle, then RUN. `samp_cnt` is cleared.
- RUN:
  - `in_ready=1` and `run = in_valid`. An acceptance is `in_valid & in_ready`.
  - `samp_cnt` increments on each acceptance and saturates at FILL_SAMPLES.
  - A channel acceptance goes to UPDATE. The channel handshake has priority over `enable=0`.
  - `enable=0` with no channel acceptance goes to IDLE. `loaded` is kept, so a re-enable re-runs UPDATE and INIT.
- Output tracking: a DECODE_LAT-deep shift register `vpipe`. On each acceptance, `vpipe[0] <= (samp_cnt >= FILL_SAMPLES)` (pre-increment value); otherwise 0. `out_valid = vpipe[DECODE_LAT-1]`.
- Flush: `vpipe` clears to all zeros in any cycle where the FSM leaves RUN. In-flight decisions are discarded.
- Strobes, `chan_ready` and `in_ready` decode from the registered state (Moore), except `run`, which also depends on `in_valid`. The strobes are mutually exclusive.
- Counter widths: `$clog2(N+1)`.

## Timing
- Reset values:
  - state=IDLE, `loaded=0`, `est_channel`=all 0, counters 0, `vpipe`=0.
  - Therefore `update=initialize=run=in_ready=out_valid=0` and `chan_ready=1`.
- Reset mid-operation, in any state, forces this condition on the next edge. Pending strobes stop immediately.
- Latency:
  - Acceptance in IDLE with `enable=1` at cycle t: `update` is high for t+1..t+UPDATE_CYCLES.
  - `initialize` is high at t+UPDATE_CYCLES+1.
  - `in_ready` is first high at t+UPDATE_CYCLES+2.
- A sample accepted at cycle s drives `out_valid` at s+DECODE_LAT, provided it is the (FILL_SAMPLES+1)th or later sample since INIT and RUN is not exited before then.
- `in_valid` gaps produce matching `out_valid` gaps. `samp_cnt` holds during gaps.
- Channel acceptance in RUN at cycle t:
  - `run` may still be 1 at t.
  - `update` is high from t+1, using the new `est_channel` already present from t+1.

## Test plan
- Bring-up: reset, `enable=1`, one channel handshake at cycle 5 -> `update` high in cycles 6-8, `initialize` in cycle 9, `in_ready` from cycle 10, `est_channel` equals `chan_in` from cycle 6.
- Fill and latency: continuous `in_valid` from cycle 10 -> the first 8 samples give no `out_valid`; the first `out_valid` is at cycle 22 (sample 8 accepted at 18, plus 4); it then stays high every cycle.
- Gapped input: `in_valid` pattern 1,0,1,1,0 after fill -> `run` and `out_valid` reproduce the pattern, delayed by 4 cycles for `out_valid`; `samp_cnt` is unchanged on the 0 cycles.
- Mid-run reload: channel handshake during RUN with `enable` low the same cycle -> next state is UPDATE (not IDLE), `vpipe` is flushed with no `out_valid` for the next 4 cycles, and fill restarts after INIT.
- Disable and re-enable: `enable=0` in RUN -> IDLE next cycle and `in_ready=0`; `enable=1` with no new channel -> UPDATE (3 cycles), INIT, RUN, with `est_channel` unchanged.
- Reset in UPDATE at the 2nd `update` cycle -> the next cycle shows state=0, all strobes 0, and `est_channel`=0; with `enable=1` and no new channel offered, the FSM stays in IDLE because `loaded=0`.
